turing_machine_prog: RTL and testbench
======================================

Name: turing_machine_prog

Overview:
- Parameterised single-tape binary Turing machine with a run-time programmable rule table.
- Generalises our fixed "set first zero from MSB" machine. Tape width, state count and step limit are parameters. The head can move in both directions. Execution stops on a halt rule, a head-out-of-range fault, or a step-limit timeout.
- Sits behind the host control logic: the host loads rules, then launches runs with start, then reads back tape/flags.

Parameters:
- TAPE_W, 8, tape length in bits; head index range 0..TAPE_W-1. HW = $clog2(TAPE_W), derived localparam.
- NSTATES, 4, machine states, power of two, >= 2. SW = $clog2(NSTATES), derived localparam.
- STEP_W, 8, width of step counter.
- MAX_STEPS, 200, step limit, 1 <= MAX_STEPS <= 2^STEP_W-1.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  launch pulse; sampled only in IDLE/DONE
- tape_in  in  TAPE_W  initial tape, captured on start
- head_init  in  HW  initial head index, captured on start
- rule_we  in  1  rule table write enable; ignored while busy
- rule_addr  in  SW+1  {state, read_symbol}
- rule_data  in  SW+3  {next_state[SW-1:0], write_bit, move, halt}; move=1 head+1, move=0 head-1
- busy  out  1  high in RUN
- done  out  1  high in DONE
- halted  out  1  run ended on halt rule
- timeout  out  1  run ended on step limit
- fault  out  1  run ended on head leaving tape
- tape_out  out  TAPE_W  live tape register
- head_pos  out  HW  live head index
- tm_state  out  SW  live machine state
- step_count  out  STEP_W  executed (non-halt) steps

Behaviour:
- Reset (takes priority over everything, including mid-run): FSM=IDLE; tape_out=0, head_pos=0, tm_state=0, step_count=0; busy/done/halted/timeout/fault=0. All 2*NSTATES rule entries = {0,0,0,halt=1}, so an unprogrammed machine halts on its first lookup.
- Rule write: with rule_we=1 and not busy, entry[rule_addr] <= rule_data at the edge. Usable in IDLE and DONE. Same-cycle rule_we and start: the write lands first and is visible to step 1.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge k:
  - tape_out<=tape_in, head_pos<=head_init, tm_state<=0, step_count<=0.
  - Clear done/halted/timeout/fault; enter RUN (busy=1 after edge k).
- RUN, one rule lookup per cycle, sym = tape_out[head_pos], r = entry[{tm_state,sym}]:
  - r.halt=1: no write/move/state change, step_count unchanged; halted<=1, enter DONE.
  - Otherwise, a step is executed: tape_out[head_pos]<=r.write_bit, tm_state<=r.next_state, step_count+1.
    - Head moves per r.move if the target index is in 0..TAPE_W-1.
    - Move past either end (head=TAPE_W-1 with move=1, head=0 with move=0): write and state update still commit, head stays, fault<=1, enter DONE.
    - If the incremented step_count == MAX_STEPS and the machine has not already ended: timeout<=1, enter DONE.
    - Fault and timeout on the same step: both flags set.
- Latency: if the halt rule is the n-th lookup, done rises after edge k+n. start and head_init are ignored in RUN.
- DONE: all outputs held until start or reset; start relaunches directly (no IDLE pass).
- Exactly one of halted/timeout/fault is set in DONE, except the fault+timeout coincidence.

Test Plan:
- Program: (0,1)->{0,1,move0}; (0,0)->{1,1,move0}; (1,x) halt. TAPE_W=8, tape_in=8'b1101_0111, head_init=7, start at edge k -> done after k+4; tape_out=8'b1111_0111, step_count=3, head_pos=4, tm_state=1, halted=1.
- Reset, then no rule writes, start with tape_in=8'hA5 -> done after 1 cycle, halted=1, step_count=0, tape_out=8'hA5.
- Ping-pong rules (0,b)->{1,b,move1}, (1,b)->{0,b,move0}; MAX_STEPS=10, head_init=3 -> done after 10 cycles, timeout=1, step_count=10, head_pos=3, tape unchanged.
- Rules: all entries {0,0,move0,no halt}; head_init=2, tape_in=8'hFF -> after 3 steps fault=1, head_pos=0, tape_out=8'hF8, step_count=3.
- Assert reset on cycle 2 of a RUN -> next cycle busy=0, all outputs 0, rule table back to halt; subsequent start halts after 1 cycle.
- rule_we pulsed during RUN -> table unchanged, run result identical to the undisturbed run. Start from DONE with new tape -> flags cleared, run repeats correctly.

Source files
------------

// File: rtl/turing_machine_prog_if.sv
// turing_machine_prog_if: host-side control, rule-load and status bundle for the programmable Turing machine
interface turing_machine_prog_if #(
    parameter int TAPE_W  = 8,
    parameter int NSTATES = 4,
    parameter int STEP_W  = 8
);
    localparam int HW = $clog2(TAPE_W);
    localparam int SW = $clog2(NSTATES);
    logic              start;
    logic [TAPE_W-1:0] tape_in;
    logic [HW-1:0]     head_init;
    logic              rule_we;
    logic [SW:0]       rule_addr;
    logic [SW+2:0]     rule_data;
    logic              busy;
    logic              done;
    logic              halted;
    logic              timeout;
    logic              fault;
    logic [TAPE_W-1:0] tape_out;
    logic [HW-1:0]     head_pos;
    logic [SW-1:0]     tm_state;
    logic [STEP_W-1:0] step_count;
    modport master (
        output start, tape_in, head_init, rule_we, rule_addr, rule_data,
        input  busy, done, halted, timeout, fault, tape_out, head_pos, tm_state, step_count
    );
    modport slave (
        input  start, tape_in, head_init, rule_we, rule_addr, rule_data,
        output busy, done, halted, timeout, fault, tape_out, head_pos, tm_state, step_count
    );
endinterface

// File: rtl/turing_machine_prog.sv
// turing_machine_prog: single-tape binary Turing machine with a run-time programmable rule table,
// stopping on a halt rule, the head leaving the tape, or a step-limit timeout
module turing_machine_prog #(
    parameter int TAPE_W    = 8,
    parameter int NSTATES   = 4,
    parameter int STEP_W    = 8,
    parameter int MAX_STEPS = 200
) (
    input logic clk,
    input logic reset,
    turing_machine_prog_if.slave bus
);
    localparam int HW = $clog2(TAPE_W);
    localparam int SW = $clog2(NSTATES);
    localparam int RW = SW + 3;
    localparam int NE = 2 * NSTATES;

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t              fsm, fsm_nx;
    logic [RW-1:0]     rules [NE];
    logic [TAPE_W-1:0] tape, tape_nx;
    logic [HW-1:0]     head, head_nx;
    logic [SW-1:0]     st, st_nx;
    logic [STEP_W-1:0] cnt, cnt_nx;
    logic              halted, halted_nx, timeout, timeout_nx, fault, fault_nx;
    logic [RW-1:0]     r;
    logic              off_edge;

    // rule layout: {next_state, write_bit, move, halt}
    assign r = rules[{st, tape[head]}];

    always_comb begin
        fsm_nx     = fsm;
        tape_nx    = tape;
        head_nx    = head;
        st_nx      = st;
        cnt_nx     = cnt;
        halted_nx  = halted;
        timeout_nx = timeout;
        fault_nx   = fault;
        off_edge   = 1'b0;
        if (fsm != RUN && bus.start) begin
            tape_nx    = bus.tape_in;
            head_nx    = bus.head_init;
            st_nx      = '0;
            cnt_nx     = '0;
            halted_nx  = 1'b0;
            timeout_nx = 1'b0;
            fault_nx   = 1'b0;
            fsm_nx     = RUN;
        end else if (fsm == RUN) begin
            if (r[0]) begin
                halted_nx = 1'b1;
                fsm_nx    = DONE;
            end else begin
                tape_nx[head] = r[2];
                st_nx         = r[RW-1:3];
                cnt_nx        = cnt + 1'b1;
                off_edge      = r[1] ? (head == HW'(TAPE_W - 1)) : (head == '0);
                head_nx       = off_edge ? head : (r[1] ? head + 1'b1 : head - 1'b1);
                fault_nx      = off_edge;
                fsm_nx        = off_edge ? DONE : fsm;
                // a fault on the limiting step reports both causes
                if (cnt_nx == STEP_W'(MAX_STEPS)) begin
                    timeout_nx = 1'b1;
                    fsm_nx     = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm     <= IDLE;
            tape    <= '0;
            head    <= '0;
            st      <= '0;
            cnt     <= '0;
            halted  <= 1'b0;
            timeout <= 1'b0;
            fault   <= 1'b0;
            for (int i = 0; i < NE; i++) rules[i] <= RW'(1);
        end else begin
            fsm     <= fsm_nx;
            tape    <= tape_nx;
            head    <= head_nx;
            st      <= st_nx;
            cnt     <= cnt_nx;
            halted  <= halted_nx;
            timeout <= timeout_nx;
            fault   <= fault_nx;
            if (bus.rule_we && fsm != RUN) rules[bus.rule_addr] <= bus.rule_data;
        end
    end

    assign bus.busy       = fsm == RUN;
    assign bus.done       = fsm == DONE;
    assign bus.halted     = halted;
    assign bus.timeout    = timeout;
    assign bus.fault      = fault;
    assign bus.tape_out   = tape;
    assign bus.head_pos   = head;
    assign bus.tm_state   = st;
    assign bus.step_count = cnt;
endmodule

// File: tb/tb_turing_machine_prog.sv
// tb_turing_machine_prog: directed vectors with hand-computed results for the programmable Turing machine
module tb_turing_machine_prog;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    turing_machine_prog_if #(.TAPE_W(8), .NSTATES(4), .STEP_W(8)) bus ();

    turing_machine_prog #(.TAPE_W(8), .NSTATES(4), .STEP_W(8), .MAX_STEPS(10)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rd(input logic [1:0] ns, input logic wr, input logic mv, input logic h);
        return {ns, wr, mv, h};
    endfunction

    task automatic wrule(input logic [2:0] a, input logic [4:0] d);
        bus.rule_we   = 1'b1;
        bus.rule_addr = a;
        bus.rule_data = d;
        tick();
        bus.rule_we = 1'b0;
    endtask

    task automatic launch(input logic [7:0] t, input logic [2:0] h);
        bus.tape_in   = t;
        bus.head_init = h;
        bus.start     = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic prog_basic();
        wrule(3'b001, rd(2'd0, 1'b1, 1'b0, 1'b0));
        wrule(3'b000, rd(2'd1, 1'b1, 1'b0, 1'b0));
        wrule(3'b010, rd(2'd0, 1'b0, 1'b0, 1'b1));
        wrule(3'b011, rd(2'd0, 1'b0, 1'b0, 1'b1));
    endtask

    task automatic check_basic(input string tag);
        chk({tag, "_lat"}, cyc, 4);
        chk({tag, "_tape"}, bus.tape_out, 8'hF7);
        chk({tag, "_steps"}, bus.step_count, 3);
        chk({tag, "_head"}, bus.head_pos, 4);
        chk({tag, "_state"}, bus.tm_state, 1);
        chk({tag, "_flags"}, {bus.halted, bus.timeout, bus.fault}, 3'b100);
    endtask

    initial begin
        bus.start = 1'b0; bus.tape_in = '0; bus.head_init = '0;
        bus.rule_we = 1'b0; bus.rule_addr = '0; bus.rule_data = '0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_ctl", {bus.busy, bus.done, bus.halted, bus.timeout, bus.fault}, 5'b0);
        chk("rst_regs", {bus.tape_out, bus.head_pos, bus.tm_state, bus.step_count}, 0);

        // unprogrammed table halts on the first lookup
        launch(8'hA5, 3'd0);
        chk("unprog_busy", bus.busy, 1);
        wait_done(cyc);
        chk("unprog_lat", cyc, 1);
        chk("unprog_flags", {bus.halted, bus.timeout, bus.fault}, 3'b100);
        chk("unprog_steps", bus.step_count, 0);
        chk("unprog_tape", bus.tape_out, 8'hA5);

        prog_basic();
        launch(8'b1101_0111, 3'd7);
        wait_done(cyc);
        check_basic("basic");

        // ping-pong hits the step limit; relaunch from DONE clears halted
        wrule(3'b000, rd(2'd1, 1'b0, 1'b1, 1'b0));
        wrule(3'b001, rd(2'd1, 1'b1, 1'b1, 1'b0));
        wrule(3'b010, rd(2'd0, 1'b0, 1'b0, 1'b0));
        wrule(3'b011, rd(2'd0, 1'b1, 1'b0, 1'b0));
        launch(8'h3C, 3'd3);
        chk("pp_relaunch", {bus.busy, bus.done, bus.halted}, 3'b100);
        wait_done(cyc);
        chk("pp_lat", cyc, 10);
        chk("pp_flags", {bus.halted, bus.timeout, bus.fault}, 3'b010);
        chk("pp_steps", bus.step_count, 10);
        chk("pp_head", bus.head_pos, 3);
        chk("pp_tape", bus.tape_out, 8'h3C);

        for (int i = 0; i < 4; i++) wrule(3'(i), rd(2'd0, 1'b0, 1'b0, 1'b0));
        launch(8'hFF, 3'd2);
        wait_done(cyc);
        chk("flt_lat", cyc, 3);
        chk("flt_flags", {bus.halted, bus.timeout, bus.fault}, 3'b001);
        chk("flt_head", bus.head_pos, 0);
        chk("flt_tape", bus.tape_out, 8'hF8);
        chk("flt_steps", bus.step_count, 3);

        // rule writes while busy must be dropped
        prog_basic();
        launch(8'b1101_0111, 3'd7);
        bus.rule_we = 1'b1; bus.rule_addr = 3'b001; bus.rule_data = rd(2'd0, 1'b0, 1'b0, 1'b1);
        tick();
        bus.rule_we = 1'b0;
        wait_done(cyc);
        cyc++;
        check_basic("we_busy");
        launch(8'b1101_0111, 3'd7);
        wait_done(cyc);
        check_basic("we_rerun");

        launch(8'b1101_0111, 3'd7);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_ctl", {bus.busy, bus.done, bus.halted, bus.timeout, bus.fault}, 5'b0);
        chk("midrst_regs", {bus.tape_out, bus.head_pos, bus.tm_state, bus.step_count}, 0);
        launch(8'hFF, 3'd2);
        wait_done(cyc);
        chk("midrst_lat", cyc, 1);
        chk("midrst_flags", {bus.halted, bus.step_count}, {1'b1, 8'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
